// File: rtl/cint_sequencer.sv
// Interrupt-acknowledge microsequencer: counts XPT through NMI/IM1 (12 steps) or IM2 (18 steps)
// and decodes each step into bus and register strobes. IM2 vector fetch is built only with CINT_IM2_EN.
module cint_sequencer #(
  parameter int          XPT_W   = 5,
  parameter logic [15:0] RST_VEC = 16'h0038,
  parameter logic [15:0] NMI_VEC = 16'h0066
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INT_REQ,
  input  logic             NMI_REQ,
  input  logic [1:0]       IM,
  input  logic             TWAIT,
  input  logic [7:0]       I_REG,
  input  logic [7:0]       R_REG,
  input  logic [15:0]      PC_IN,
  input  logic [15:0]      SP_IN,
  input  logic [7:0]       DIN,
  output logic [XPT_W-1:0] XPT,
  output logic             BUSY,
  output logic [15:0]      ADDR,
  output logic [7:0]       DOUT,
  output logic             M1,
  output logic             MREQ,
  output logic             IORQ,
  output logic             RD,
  output logic             WR,
  output logic             RFSH,
  output logic             INC_R,
  output logic             DEC_SP,
  output logic             PC_LOAD,
  output logic [15:0]      PC_NEXT,
  output logic             DONE
);

`ifdef CINT_IM2_EN
  localparam int MAX_STEP = 18;
`else
  localparam int MAX_STEP = 12;
`endif

  logic [XPT_W-1:0] xpt_q, xpt_d;
  logic             nmi_q, nmi_d;
  logic [7:0]       vec_q, vec_d;
  logic             im2;
  logic [MAX_STEP:0] s;
  logic             wait_step, final_step, advance;

`ifdef CINT_IM2_EN
  logic       im2_q, im2_d;
  logic [7:0] tgt_q, tgt_d;
  assign im2 = im2_q;
`else
  assign im2 = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{IM, vec_q};

  // One-hot view of the step counter; s[0] is idle.
  always_comb begin
    for (int n = 0; n <= MAX_STEP; n++) s[n] = (int'(xpt_q) == n);
  end

  always_comb begin
    wait_step = s[3] | s[8] | s[11];
    final_step = s[12];
`ifdef CINT_IM2_EN
    wait_step = wait_step | (im2 & (s[15] | s[18]));
    final_step = im2 ? s[18] : s[12];
`endif
    advance = !(wait_step && TWAIT);
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      xpt_q <= '0;
      nmi_q <= 1'b0;
      vec_q <= 8'h00;
`ifdef CINT_IM2_EN
      im2_q <= 1'b0;
      tgt_q <= 8'h00;
`endif
    end else begin
      xpt_q <= xpt_d;
      nmi_q <= nmi_d;
      vec_q <= vec_d;
`ifdef CINT_IM2_EN
      im2_q <= im2_d;
      tgt_q <= tgt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    xpt_d = xpt_q;
    nmi_d = nmi_q;
    vec_d = vec_q;
`ifdef CINT_IM2_EN
    im2_d = im2_q;
    tgt_d = tgt_q;
`endif
    if (s[0]) begin
      if (NMI_REQ) begin
        xpt_d = XPT_W'(1);
        nmi_d = 1'b1;
`ifdef CINT_IM2_EN
        im2_d = 1'b0;
`endif
      end else if (INT_REQ) begin
        xpt_d = XPT_W'(1);
        nmi_d = 1'b0;
`ifdef CINT_IM2_EN
        im2_d = (IM == 2'd2);
`endif
      end
    end else if (advance) begin
      xpt_d = final_step ? '0 : xpt_q + XPT_W'(1);
      if (s[3]) vec_d = DIN;
`ifdef CINT_IM2_EN
      if (s[15]) tgt_d = DIN;
`endif
    end
  end

  // Output decode
  always_comb begin
    ADDR = 16'h0000; DOUT = 8'h00; M1 = 1'b0; MREQ = 1'b0; IORQ = 1'b0; RD = 1'b0;
    WR = 1'b0; RFSH = 1'b0; INC_R = 1'b0; DEC_SP = 1'b0; PC_LOAD = 1'b0; DONE = 1'b0;
    PC_NEXT = 16'h0000;
    if (s[1] | s[2] | s[3]) begin
      ADDR = PC_IN;
      M1   = 1'b1;
      if (nmi_q) begin
        MREQ = s[3];
        RD   = s[3];
      end else begin
        IORQ = s[2] | s[3];
        RD   = s[3];
      end
    end
    if (s[4] | s[5]) begin
      ADDR  = {I_REG, R_REG};
      RFSH  = 1'b1;
      MREQ  = s[4];
      INC_R = s[5];
    end
    if (s[6]) DEC_SP = 1'b1;
    if (s[7] | s[8] | s[9]) begin
      ADDR   = SP_IN;
      DOUT   = PC_IN[15:8];
      MREQ   = s[7] | s[8];
      WR     = s[8];
      DEC_SP = s[9];
    end
    if (s[10] | s[11] | s[12]) begin
      ADDR = SP_IN;
      DOUT = PC_IN[7:0];
      MREQ = s[10] | s[11];
      WR   = s[11];
    end
`ifdef CINT_IM2_EN
    if (im2 && (s[13] | s[14] | s[15])) begin
      ADDR = {I_REG, vec_q[7:1], 1'b0};
      MREQ = s[13] | s[14];
      RD   = s[14];
    end
    if (im2 && (s[16] | s[17] | s[18])) begin
      ADDR = {I_REG, vec_q[7:1], 1'b1};
      MREQ = s[16] | s[17];
      RD   = s[17];
    end
`endif
    if (final_step && advance) begin
      PC_LOAD = 1'b1;
      DONE    = 1'b1;
`ifdef CINT_IM2_EN
      PC_NEXT = nmi_q ? NMI_VEC : (im2 ? {DIN, tgt_q} : RST_VEC);
`else
      PC_NEXT = nmi_q ? NMI_VEC : RST_VEC;
`endif
    end
  end

  assign XPT  = xpt_q;
  assign BUSY = |xpt_q;

endmodule

// File: tb/tb_cint_sequencer.sv
// Bench for cint_sequencer: step table for IM1, hand sequences for NMI, waits, IM2 and reset,
// with a DONE scoreboard checking PC_NEXT and request-to-DONE latency.
module tb_cint_sequencer;
  localparam int XPT_W = 5;

  logic             CLK, RESET, INT_REQ, NMI_REQ, TWAIT;
  logic [1:0]       IM;
  logic [7:0]       I_REG, R_REG, DIN, DOUT;
  logic [15:0]      PC_IN, SP_IN, ADDR, PC_NEXT;
  logic [XPT_W-1:0] XPT;
  logic             BUSY, M1, MREQ, IORQ, RD, WR, RFSH, INC_R, DEC_SP, PC_LOAD, DONE;

  cint_sequencer #(.XPT_W(XPT_W)) dut (
    .CLK(CLK), .RESET(RESET), .INT_REQ(INT_REQ), .NMI_REQ(NMI_REQ), .IM(IM), .TWAIT(TWAIT),
    .I_REG(I_REG), .R_REG(R_REG), .PC_IN(PC_IN), .SP_IN(SP_IN), .DIN(DIN),
    .XPT(XPT), .BUSY(BUSY), .ADDR(ADDR), .DOUT(DOUT), .M1(M1), .MREQ(MREQ), .IORQ(IORQ),
    .RD(RD), .WR(WR), .RFSH(RFSH), .INC_R(INC_R), .DEC_SP(DEC_SP), .PC_LOAD(PC_LOAD),
    .PC_NEXT(PC_NEXT), .DONE(DONE)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [9:0] strb;
  assign strb = {M1, MREQ, IORQ, RD, WR, RFSH, INC_R, DEC_SP, PC_LOAD, DONE};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: expected PC_NEXT and latency pushed per request, popped on DONE
  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          lat;

  always @(negedge CLK) begin
    if (RESET || !BUSY) lat = 0;
    else lat++;
    if (DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(DONE), 64'd0);
      end else begin
        logic [15:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("done_pc_next", 64'(PC_NEXT), 64'(e));
        check("done_latency", 64'(lat), 64'(l));
      end
    end
  end

  // Observations collected by run_seq
  logic [15:0] rd_addr_q[$];
  int hold_seen, hold_strb, iorq_seen, m1_mreq_rd, max_xpt;

  task automatic run_seq(input logic nmi, input logic intr, input logic [1:0] im,
                         input int wait_step, input int wait_n);
    int k, held, cyc;
    NMI_REQ = nmi; INT_REQ = intr; IM = im;
    step();
    NMI_REQ = 1'b0; INT_REQ = 1'b0;
    k = 1; held = 0; cyc = 0;
    hold_seen = 0; hold_strb = 0; iorq_seen = 0; m1_mreq_rd = 0; max_xpt = 0;
    rd_addr_q.delete();
    while (BUSY && cyc < 60) begin
      DIN   = (k == 3) ? 8'hF1 : (k == 15) ? 8'hCD : (k == 18) ? 8'hAB : 8'h00;
      TWAIT = (k == wait_step) && (held < wait_n);
      #1;
      if (int'(XPT) == wait_step) begin
        hold_seen++;
        if (IORQ || WR) hold_strb++;
      end
      if (IORQ) iorq_seen++;
      if (M1 && MREQ && RD) m1_mreq_rd++;
      if (RD && !M1) rd_addr_q.push_back(ADDR);
      if (int'(XPT) > max_xpt) max_xpt = int'(XPT);
      if (TWAIT) held++;
      else k++;
      step();
      cyc++;
    end
    TWAIT = 1'b0;
    DIN = 8'h00;
    check("seq_returns_idle", 64'(BUSY), 64'd0);
  endtask

  typedef struct {
    logic [4:0]  xpt;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [9:0]  strb;
    logic [15:0] pc_next;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Strobe order: M1 MREQ IORQ RD WR RFSH INC_R DEC_SP PC_LOAD DONE
    tbl[0]  = '{5'd1,  16'h1234, 8'h00, 10'h200, 16'h0000};
    tbl[1]  = '{5'd2,  16'h1234, 8'h00, 10'h280, 16'h0000};
    tbl[2]  = '{5'd3,  16'h1234, 8'h00, 10'h2C0, 16'h0000};
    tbl[3]  = '{5'd4,  16'h8005, 8'h00, 10'h110, 16'h0000};
    tbl[4]  = '{5'd5,  16'h8005, 8'h00, 10'h018, 16'h0000};
    tbl[5]  = '{5'd6,  16'h0000, 8'h00, 10'h004, 16'h0000};
    tbl[6]  = '{5'd7,  16'hFFFE, 8'h12, 10'h100, 16'h0000};
    tbl[7]  = '{5'd8,  16'hFFFE, 8'h12, 10'h120, 16'h0000};
    tbl[8]  = '{5'd9,  16'hFFFE, 8'h12, 10'h004, 16'h0000};
    tbl[9]  = '{5'd10, 16'hFFFE, 8'h34, 10'h100, 16'h0000};
    tbl[10] = '{5'd11, 16'hFFFE, 8'h34, 10'h120, 16'h0000};
    tbl[11] = '{5'd12, 16'hFFFE, 8'h34, 10'h003, 16'h0038};

    RESET = 1'b1; INT_REQ = 1'b0; NMI_REQ = 1'b0; TWAIT = 1'b0; IM = 2'd1;
    I_REG = 8'h80; R_REG = 8'h05; PC_IN = 16'h1234; SP_IN = 16'hFFFE; DIN = 8'h00;
    #1;
    check("reset_outputs", 64'({XPT, BUSY, ADDR, DOUT, strb, PC_NEXT}), 64'd0);
    repeat (2) step();
    RESET = 1'b0;
    step();

    // INT IM1 step table
    exp_q.push_back(16'h0038); lat_q.push_back(12);
    INT_REQ = 1'b1; IM = 2'd1;
    step();
    INT_REQ = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("tbl_step%0d", i + 1), 64'({XPT, ADDR, DOUT, strb, PC_NEXT}),
            64'({tbl[i].xpt, tbl[i].addr, tbl[i].dout, tbl[i].strb, tbl[i].pc_next}));
      step();
    end
    check("tbl_back_to_idle", 64'(BUSY), 64'd0);

    // NMI and INT together: NMI wins
    exp_q.push_back(16'h0066); lat_q.push_back(12);
    run_seq(1'b1, 1'b1, 2'd1, 0, 0);
    check("nmi_no_iorq", 64'(iorq_seen), 64'd0);
    check("nmi_m1_mreq_rd", 64'(m1_mreq_rd), 64'd1);

    // IM0 behaves as IM1
    exp_q.push_back(16'h0038); lat_q.push_back(12);
    run_seq(1'b0, 1'b1, 2'd0, 0, 0);
    check("im0_iorq_cycles", 64'(iorq_seen), 64'd2);

    // Wait at step 3 for 3 cycles
    exp_q.push_back(16'h0038); lat_q.push_back(15);
    run_seq(1'b0, 1'b1, 2'd1, 3, 3);
    check("wait3_hold", 64'(hold_seen), 64'd4);
    check("wait3_iorq_held", 64'(hold_strb), 64'd4);

    // Wait at step 8 (write) for 2 cycles
    exp_q.push_back(16'h0038); lat_q.push_back(14);
    run_seq(1'b0, 1'b1, 2'd1, 8, 2);
    check("wait8_hold", 64'(hold_seen), 64'd3);
    check("wait8_wr_held", 64'(hold_strb), 64'd3);

    // IM2 vector fetch
`ifdef CINT_IM2_EN
    exp_q.push_back(16'hABCD); lat_q.push_back(18);
    run_seq(1'b0, 1'b1, 2'd2, 0, 0);
    check("im2_rd_count", 64'(rd_addr_q.size()), 64'd2);
    if (rd_addr_q.size() == 2) begin
      check("im2_rd_lo", 64'(rd_addr_q[0]), 64'h80F0);
      check("im2_rd_hi", 64'(rd_addr_q[1]), 64'h80F1);
    end
    check("im2_max_xpt", 64'(max_xpt), 64'd18);
    exp_q.push_back(16'hABCD); lat_q.push_back(20);
    run_seq(1'b0, 1'b1, 2'd2, 18, 2);
    check("im2_wait18_hold", 64'(hold_seen), 64'd3);
`else
    exp_q.push_back(16'h0038); lat_q.push_back(12);
    run_seq(1'b0, 1'b1, 2'd2, 0, 0);
    check("im2off_rd_count", 64'(rd_addr_q.size()), 64'd0);
    check("im2off_max_xpt", 64'(max_xpt), 64'd12);
`endif

    // Reset in the middle of the sequence at step 9
    INT_REQ = 1'b1; IM = 2'd1;
    step();
    INT_REQ = 1'b0;
    repeat (8) step();
    check("pre_reset_xpt", 64'(XPT), 64'd9);
    RESET = 1'b1;
    #1;
    check("mid_reset_outputs", 64'({XPT, BUSY, ADDR, DOUT, strb, PC_NEXT}), 64'd0);
    step();
    RESET = 1'b0;
    step();
    check("post_reset_idle", 64'(BUSY), 64'd0);
    exp_q.push_back(16'h0038); lat_q.push_back(12);
    run_seq(1'b0, 1'b1, 2'd1, 0, 0);

    step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
